// File: rtl/mic1_bus_pkg.sv
// Shared definitions for the Mic-1 byte-serial memory bus: FSM states,
// request header layout and word size.
package mic1_bus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_e;

  localparam int HDR_WE       = 7;
  localparam int HDR_WORD     = 6;
  localparam int HDR_RSVD_MSB = 5;
  localparam int HDR_RSVD_LSB = 0;
  localparam int WORD_BYTES   = 4;

  // True when any reserved header bit is set.
  function automatic logic hdr_rsvd_bad(input logic [7:0] hdr);
    return |hdr[HDR_RSVD_MSB:HDR_RSVD_LSB];
  endfunction

endpackage

// File: rtl/mic1_resp_ram.sv
// Single-port DEPTH x 8 byte RAM, synchronous write and synchronous read.
// Contents are deliberately not reset.
module mic1_resp_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Write-first is irrelevant here: the FSM never reads and writes the same cycle it needs the data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mic1_mem_responder.sv
// Memory-side responder for the Mic-1 byte-serial pin bus.
// Optional protocol-error detection is built when MIC1_RESP_ERR_EN is defined.
module mic1_mem_responder
  import mic1_bus_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int ADDR_BYTES = 2,
  parameter int RD_LAT     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cpu_bus,
  input  logic       cpu_strb,
  output logic [7:0] rsp_data,
  output logic       rsp_ack,
  output logic       busy,
  output logic       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (ADDR_BYTES > WORD_BYTES) ? $clog2(ADDR_BYTES) : $clog2(WORD_BYTES);
  localparam int LW = $clog2(RD_LAT + 1);

  state_e        state_r, state_nxt;
  logic [CW-1:0] cnt_r, cnt_nxt;
  logic [LW-1:0] lat_r, lat_nxt;
  logic [AW-1:0] ptr_r, ptr_nxt;
  logic [AW-1:0] addr_r, addr_nxt;
  logic          we_r, we_nxt;
  logic          word_r, word_nxt;
  logic [7:0]    rsp_data_r, rsp_data_nxt;
  logic          rsp_ack_r, rsp_ack_nxt;
  logic          busy_r;
  logic          ram_we_s;
  logic [7:0]    ram_rdata_s;
  logic [CW-1:0] last_idx_s;

  assign last_idx_s = word_r ? CW'(WORD_BYTES - 1) : CW'(0);

  mic1_resp_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .addr  (ptr_r),
    .wdata (cpu_bus),
    .rdata (ram_rdata_s)
  );

  // Next-state, datapath and response decode.
  // The pointer runs one byte ahead of the response so the synchronous RAM output is ready in time.
  always_comb begin
    state_nxt    = state_r;
    cnt_nxt      = cnt_r;
    lat_nxt      = lat_r;
    ptr_nxt      = ptr_r;
    addr_nxt     = addr_r;
    we_nxt       = we_r;
    word_nxt     = word_r;
    rsp_data_nxt = 8'h00;
    rsp_ack_nxt  = 1'b0;
    ram_we_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (cpu_strb) begin
          we_nxt    = cpu_bus[HDR_WE];
          word_nxt  = cpu_bus[HDR_WORD];
          cnt_nxt   = CW'(0);
          state_nxt = ADDR;
        end else begin
          state_nxt = IDLE;
        end
      end
      ADDR: begin
        if (cpu_strb) begin
          addr_nxt = AW'({addr_r, cpu_bus});
          if (cnt_r == CW'(ADDR_BYTES - 1)) begin
            cnt_nxt   = CW'(0);
            lat_nxt   = LW'(RD_LAT);
            ptr_nxt   = word_r ? {addr_nxt[AW-3:0], 2'b00} : addr_nxt;
            state_nxt = we_r ? WDATA : WAIT;
          end else begin
            cnt_nxt = cnt_r + CW'(1);
          end
        end else begin
          state_nxt = ADDR;
        end
      end
      WDATA: begin
        if (cpu_strb) begin
          ram_we_s = 1'b1;
          ptr_nxt  = ptr_r + AW'(1);
          if (cnt_r == last_idx_s) begin
            cnt_nxt   = CW'(0);
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt_r + CW'(1);
          end
        end else begin
          state_nxt = WDATA;
        end
      end
      WAIT: begin
        if (lat_r == LW'(0)) begin
          rsp_ack_nxt  = 1'b1;
          rsp_data_nxt = ram_rdata_s;
          cnt_nxt      = CW'(0);
          ptr_nxt      = ptr_r + AW'(1);
          state_nxt    = RESP;
        end else begin
          lat_nxt = lat_r - LW'(1);
          if (lat_r == LW'(1)) begin
            ptr_nxt = ptr_r + AW'(1);
          end else begin
            ptr_nxt = ptr_r;
          end
        end
      end
      RESP: begin
        if (cnt_r == last_idx_s) begin
          cnt_nxt   = CW'(0);
          state_nxt = IDLE;
        end else begin
          rsp_ack_nxt  = 1'b1;
          rsp_data_nxt = ram_rdata_s;
          cnt_nxt      = cnt_r + CW'(1);
          ptr_nxt      = ptr_r + AW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset aborts any transaction at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= CW'(0);
      lat_r      <= LW'(0);
      ptr_r      <= AW'(0);
      addr_r     <= AW'(0);
      we_r       <= 1'b0;
      word_r     <= 1'b0;
      rsp_data_r <= 8'h00;
      rsp_ack_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      cnt_r      <= cnt_nxt;
      lat_r      <= lat_nxt;
      ptr_r      <= ptr_nxt;
      addr_r     <= addr_nxt;
      we_r       <= we_nxt;
      word_r     <= word_nxt;
      rsp_data_r <= rsp_data_nxt;
      rsp_ack_r  <= rsp_ack_nxt;
      busy_r     <= (state_nxt != IDLE);
    end
  end

  assign rsp_data = rsp_data_r;
  assign rsp_ack  = rsp_ack_r;
  assign busy     = busy_r;

`ifdef MIC1_RESP_ERR_EN
  logic err_r;
  logic err_hit_s;

  // Protocol violations: strobes during a read, or a header with reserved bits set.
  always_comb begin
    err_hit_s = 1'b0;
    if (cpu_strb && ((state_r == WAIT) || (state_r == RESP))) begin
      err_hit_s = 1'b1;
    end else if (cpu_strb && (state_r == IDLE) && hdr_rsvd_bad(cpu_bus)) begin
      err_hit_s = 1'b1;
    end else begin
      err_hit_s = 1'b0;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | err_hit_s;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mic1_mem_responder.sv
// Directed self-checking bench for mic1_mem_responder (default parameters).
module tb_mic1_mem_responder;

  localparam int RD_LAT = 2;
`ifdef MIC1_RESP_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cpu_bus;
  logic       cpu_strb;
  logic [7:0] rsp_data;
  logic       rsp_ack;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mic1_mem_responder #(
    .DEPTH      (1024),
    .ADDR_BYTES (2),
    .RD_LAT     (RD_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_bus  (cpu_bus),
    .cpu_strb (cpu_strb),
    .rsp_data (rsp_data),
    .rsp_ack  (rsp_ack),
    .busy     (busy),
    .err      (err)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request byte at the next falling edge, after 'stall' idle cycles.
  task automatic put(input logic [7:0] b, input int stall);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      cpu_strb = 1'b0;
      cpu_bus  = 8'h00;
    end
    @(negedge clk);
    cpu_bus  = b;
    cpu_strb = 1'b1;
  endtask

  task automatic release_bus();
    @(negedge clk);
    cpu_strb = 1'b0;
    cpu_bus  = 8'h00;
  endtask

  task automatic do_write(input string tag, input logic [7:0] hdr, input logic [15:0] a,
                          input logic [31:0] d, input int n, input int stall);
    put(hdr, 0);
    put(a[15:8], stall);
    put(a[7:0], stall);
    for (int k = 0; k < n; k++) begin
      put(d[31-8*k -: 8], stall);
    end
    release_bus();
    check({tag, "_busy_done"}, {7'd0, busy}, 8'h00);
  endtask

  // Issue a read and check exact ack timing and data; optionally strobe junk during WAIT.
  task automatic do_read(input string tag, input logic [7:0] hdr, input logic [15:0] a,
                         input logic [31:0] exp, input int n, input int stall, input bit junk);
    put(hdr, 0);
    put(a[15:8], stall);
    put(a[7:0], stall);
    @(negedge clk);
    if (junk) begin
      cpu_bus  = 8'hA5;
      cpu_strb = 1'b1;
    end else begin
      cpu_bus  = 8'h00;
      cpu_strb = 1'b0;
    end
    check({tag, "_busy"}, {7'd0, busy}, 8'h01);
    check({tag, "_noack0"}, {7'd0, rsp_ack}, 8'h00);
    for (int c = 1; c <= RD_LAT; c++) begin
      @(negedge clk);
      cpu_strb = 1'b0;
      cpu_bus  = 8'h00;
      check({tag, "_noack"}, {7'd0, rsp_ack}, 8'h00);
    end
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check({tag, "_ack"}, {7'd0, rsp_ack}, 8'h01);
      check({tag, "_data"}, rsp_data, exp[31-8*k -: 8]);
    end
    @(negedge clk);
    check({tag, "_ack_end"}, {7'd0, rsp_ack}, 8'h00);
    check({tag, "_data_end"}, rsp_data, 8'h00);
    check({tag, "_busy_end"}, {7'd0, busy}, 8'h00);
  endtask

  initial begin
    rst      = 1'b1;
    cpu_bus  = 8'h00;
    cpu_strb = 1'b0;
    #1;
    check("rst_ack", {7'd0, rsp_ack}, 8'h00);
    check("rst_data", rsp_data, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_err", {7'd0, err}, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1/2: word write then word read at word address 5 (bytes 20..23)
    do_write("t1_wr", 8'hC0, 16'h0005, 32'hDEADBEEF, 4, 0);
    do_read("t2_rd", 8'h40, 16'h0005, 32'hDEADBEEF, 4, 0, 1'b0);

    // 3: byte read inside the word, byte write at the top of RAM, read it back
    do_read("t3_brd", 8'h00, 16'h0016, 32'hBE000000, 1, 0, 1'b0);
    do_write("t3_bwr", 8'h80, 16'h03FF, 32'h5A000000, 1, 0);
    do_read("t3_wrap", 8'h00, 16'h03FF, 32'h5A000000, 1, 0, 1'b0);
    // address 0x13FF truncates to the same byte
    do_read("t3_trunc", 8'h00, 16'h13FF, 32'h5A000000, 1, 0, 1'b0);

    // 4: stalled word write/read, plus an address that wraps into word 5
    do_write("t4_wr", 8'hC0, 16'h0006, 32'hCAFEF00D, 4, 3);
    do_read("t4_rd", 8'h40, 16'h0006, 32'hCAFEF00D, 4, 3, 1'b0);
    do_read("t4_alias", 8'h40, 16'h0105, 32'hDEADBEEF, 4, 3, 1'b0);
    do_read("t4_byte", 8'h00, 16'h0019, 32'hFE000000, 1, 0, 1'b0);

    // 5: reset in the middle of the response
    put(8'h40, 0);
    put(8'h00, 0);
    put(8'h05, 0);
    release_bus();
    repeat (RD_LAT) @(negedge clk);
    @(negedge clk);
    check("t5_ack0", rsp_data, 8'hDE);
    @(negedge clk);
    check("t5_ack1", rsp_data, 8'hAD);
    rst = 1'b1;
    #1;
    check("t5_rst_ack", {7'd0, rsp_ack}, 8'h00);
    check("t5_rst_busy", {7'd0, busy}, 8'h00);
    check("t5_rst_data", rsp_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    do_read("t5_rd", 8'h40, 16'h0005, 32'hDEADBEEF, 4, 0, 1'b0);
    check("t5_err_clear", {7'd0, err}, 8'h00);

    // 6: protocol errors
    do_read("t6_junk", 8'h40, 16'h0005, 32'hDEADBEEF, 4, 0, 1'b1);
    check("t6_err_junk", {7'd0, err}, {7'd0, ERR_EXP});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_err_rst", {7'd0, err}, 8'h00);
    do_read("t6_hdr", 8'h41, 16'h0005, 32'hDEADBEEF, 4, 0, 1'b0);
    check("t6_err_hdr", {7'd0, err}, {7'd0, ERR_EXP});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
